seq_subtractor: RTL and testbench
=================================

SEQ_SUBTRACTOR -- requirements
Module: seq_subtractor

Interface
REQ-001 The module SHALL have parameter bits, default 8, which sets the operand and result width.
REQ-002 The module SHALL have parameter chunk, default 2, which sets the bits processed per cycle; bits SHALL be an integer multiple of chunk, and chunk SHALL satisfy 1 <= chunk <= bits.
REQ-003 The module SHALL have port clk, input, width 1: the single clock, rising-edge active.
REQ-004 The module SHALL have port rst, input, width 1: asynchronous, active-high reset.
REQ-005 The module SHALL have port start, input, width 1: request to begin a subtraction, sampled only in IDLE.
REQ-006 The module SHALL have port in1, input, width bits: minuend.
REQ-007 The module SHALL have port in2, input, width bits: subtrahend.
REQ-008 The module SHALL have port mode_signed, input, width 1: 1 = two's-complement operands, 0 = unsigned.
REQ-009 The module SHALL have port saturate, input, width 1: 1 = clamp the result on out-of-range, 0 = wrap modulo 2^bits.
REQ-010 The module SHALL have port busy, output, width 1: high in states BUSY and DONE.
REQ-011 The module SHALL have port done, output, width 1: a one-cycle pulse marking that out and the flags are updated.
REQ-012 The module SHALL have port out, output, width bits: the result, held until the next completion.
REQ-013 The module SHALL have port borrow, output, width 1: unsigned borrow, high when in1 < in2 unsigned, reported in both modes.
REQ-014 The module SHALL have port overflow, output, width 1: signed overflow; forced to 0 when mode_signed=0.

Function
REQ-015 The FSM SHALL have exactly the states IDLE, BUSY and DONE.
REQ-016 In IDLE with start=1 at a clock edge, the module SHALL capture in1, in2, mode_signed and saturate into internal registers, clear the internal borrow, set the chunk index to 0, and enter BUSY.
REQ-017 Inputs SHALL be ignored after capture; changes during BUSY or DONE SHALL NOT affect the result.
REQ-018 In BUSY, on each cycle, the module SHALL compute chunk k: {b_out, d} = a[k] - b[k] - b_in, write d into the working register and carry b_out to chunk k+1.
REQ-019 After bits/chunk BUSY cycles, the module SHALL enter DONE, applying the saturation and flag logic on that transition.
REQ-020 Latency: if start is sampled at edge n, done SHALL be high during the cycle following edge n + bits/chunk + 1... specifically, done SHALL be high for exactly one cycle, beginning bits/chunk + 1 edges after the start edge.
REQ-021 In DONE the module SHALL assert done=1 for one cycle and then return to IDLE unconditionally.
REQ-022 A start pulse in BUSY or DONE SHALL be dropped, with no queuing.
REQ-023 A start pulse sampled in the IDLE cycle immediately after DONE SHALL be accepted (back-to-back operation).
REQ-024 Signed overflow SHALL be defined as: sign(in1) != sign(in2) and sign(raw result) != sign(in1).
REQ-025 With saturate=0, out SHALL be the raw difference modulo 2^bits in both modes.
REQ-026 With saturate=1 and mode_signed=0 and borrow=1, out SHALL be 0.
REQ-027 With saturate=1 and mode_signed=1 and overflow=1, out SHALL be 2^(bits-1)-1 if in1 is non-negative, else 2^(bits-1) (the most negative value).
REQ-028 Flags SHALL report the unclamped condition even when saturation is applied.
REQ-029 The registers out, borrow and overflow SHALL update only on the BUSY->DONE transition, so partial results are never visible.

Reset
REQ-030 Asserting rst at any time, including mid-BUSY, SHALL immediately force state=IDLE, busy=0, done=0, out=0, borrow=0, overflow=0, and clear the internal registers.
REQ-031 An operation interrupted by reset SHALL produce no done pulse.
REQ-032 The first start sampled after rst deasserts SHALL be accepted.

Verification (bits=8, chunk=2 unless stated)
REQ-033 in1=125, in2=100, unsigned, saturate=0 -> done pulses 5 edges after the start edge; out=25, borrow=0, overflow=0.
REQ-034 in1=0, in2=1, unsigned -> with saturate=0: out=255, borrow=1; with saturate=1: out=0, borrow=1.
REQ-035 in1=0x80, in2=0x01, signed -> with saturate=0: out=0x7F, overflow=1, borrow=0; with saturate=1: out=0x80, overflow=1.
REQ-036 in1=0x7F, in2=0xFF, signed, saturate=1 -> out=0x7F, overflow=1, borrow=1; and in1=in2=200 -> out=0, borrow=0, overflow=0.
REQ-037 rst pulsed on the 2nd BUSY cycle -> all outputs 0 immediately, no done pulse; a start pulsed while busy=1 is ignored and out is unchanged.
REQ-038 Back-to-back operations, plus chunk=8 and chunk=1 builds -> latency is 2 and 9 edges respectively, with results identical to the chunk=2 build.

Source files
------------

// File: rtl/seq_subtractor_if.sv
// seq_subtractor_if: operand/result bundle for seq_subtractor
//   start        request a subtraction (sampled only when idle)
//   in1, in2     minuend / subtrahend, bits wide
//   mode_signed  1 = two's-complement operands, 0 = unsigned
//   saturate     1 = clamp out-of-range results, 0 = wrap
//   busy         operation in flight (BUSY or DONE)
//   done         one-cycle pulse when out and flags update
//   out          result, held until the next completion
//   borrow       unsigned borrow (in1 < in2 unsigned)
//   overflow     signed overflow, 0 in unsigned mode
interface seq_subtractor_if #(parameter int bits = 8);
    logic            start;
    logic [bits-1:0] in1;
    logic [bits-1:0] in2;
    logic            mode_signed;
    logic            saturate;
    logic            busy;
    logic            done;
    logic [bits-1:0] out;
    logic            borrow;
    logic            overflow;
    modport master (
        output start, in1, in2, mode_signed, saturate,
        input  busy, done, out, borrow, overflow
    );
    modport slave (
        input  start, in1, in2, mode_signed, saturate,
        output busy, done, out, borrow, overflow
    );
endinterface

// File: rtl/seq_subtractor.sv
// seq_subtractor: multi-cycle subtractor working chunk bits per cycle, LSB first
//   clk   rising-edge clock
//   rst   asynchronous active-high reset
//   bus   seq_subtractor_if slave; its bits parameter must equal this module's bits
// Parameters: bits = operand width, chunk = bits per cycle (bits % chunk == 0).
module seq_subtractor #(
    parameter int bits  = 8,
    parameter int chunk = 2
) (
    input  logic             clk,
    input  logic             rst,
    seq_subtractor_if.slave  bus
);
    localparam int n  = bits / chunk;
    localparam int iw = $clog2(n + 1);

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

    state_t          state;
    logic [bits-1:0] a, b, d, res, out_r;
    logic [iw-1:0]   idx;
    logic            sgn, sat, bin, busy_r, done_r, borrow_r, ovf_r;
    logic [chunk-1:0] a_ch, b_ch;
    logic [chunk:0]  diff;
    logic            last, ovf;

    always_comb begin
        a_ch = chunk'(a >> (int'(idx) * chunk));
        b_ch = chunk'(b >> (int'(idx) * chunk));
        diff = {1'b0, a_ch} - {1'b0, b_ch} - {{chunk{1'b0}}, bin};
        // idx reaches n only after every chunk is in d; that extra cycle finalises
        last = idx == iw'(n);
        ovf  = sgn & (a[bits-1] ^ b[bits-1]) & (d[bits-1] ^ a[bits-1]);
        // signed clamp: 0111..1 for a non-negative minuend, 1000..0 otherwise
        res  = (sat & ~sgn & bin) ? '0 :
               (sat & ovf)        ? {a[bits-1], {(bits-1){~a[bits-1]}}} : d;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            a        <= '0;
            b        <= '0;
            d        <= '0;
            idx      <= '0;
            sgn      <= 1'b0;
            sat      <= 1'b0;
            bin      <= 1'b0;
            busy_r   <= 1'b0;
            done_r   <= 1'b0;
            out_r    <= '0;
            borrow_r <= 1'b0;
            ovf_r    <= 1'b0;
        end else begin
            case (state)
                IDLE: if (bus.start) begin
                    a      <= bus.in1;
                    b      <= bus.in2;
                    sgn    <= bus.mode_signed;
                    sat    <= bus.saturate;
                    d      <= '0;
                    bin    <= 1'b0;
                    idx    <= '0;
                    busy_r <= 1'b1;
                    state  <= BUSY;
                end
                BUSY: if (last) begin
                    out_r    <= res;
                    borrow_r <= bin;
                    ovf_r    <= ovf;
                    done_r   <= 1'b1;
                    state    <= DONE;
                end else begin
                    // d starts at zero, so OR-ing the shifted chunk places it
                    d   <= d | (bits'(diff[chunk-1:0]) << (int'(idx) * chunk));
                    bin <= diff[chunk];
                    idx <= idx + 1'b1;
                end
                DONE: begin
                    done_r <= 1'b0;
                    busy_r <= 1'b0;
                    state  <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.busy     = busy_r;
    assign bus.done     = done_r;
    assign bus.out      = out_r;
    assign bus.borrow   = borrow_r;
    assign bus.overflow = ovf_r;
endmodule

// File: tb/tb_seq_subtractor.sv
// tb_seq_subtractor: directed checks of seq_subtractor in chunk=2, 8 and 1 builds
module tb_seq_subtractor;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   vectors = 0;
    int   miscompares = 0;

    int         lat [3];
    int         dc  [3];
    logic [7:0] r   [3];
    logic       bw  [3];
    logic       vf  [3];
    int         exp_lat [3] = '{5, 2, 9};

    always #5 clk = ~clk;

    seq_subtractor_if #(.bits(8)) b2 ();
    seq_subtractor_if #(.bits(8)) b8 ();
    seq_subtractor_if #(.bits(8)) b1 ();

    seq_subtractor #(.bits(8), .chunk(2)) d2 (.clk(clk), .rst(rst), .bus(b2.slave));
    seq_subtractor #(.bits(8), .chunk(8)) d8 (.clk(clk), .rst(rst), .bus(b8.slave));
    seq_subtractor #(.bits(8), .chunk(1)) d1 (.clk(clk), .rst(rst), .bus(b1.slave));

    task automatic drive(input logic [7:0] x, input logic [7:0] y, input logic s, input logic t, input logic st);
        b2.in1 = x; b2.in2 = y; b2.mode_signed = s; b2.saturate = t; b2.start = st;
        b8.in1 = x; b8.in2 = y; b8.mode_signed = s; b8.saturate = t; b8.start = st;
        b1.in1 = x; b1.in2 = y; b1.mode_signed = s; b1.saturate = t; b1.start = st;
    endtask

    // starts all three builds together, scrambles inputs after capture, records first done
    task automatic op(input logic [7:0] x, input logic [7:0] y, input logic s, input logic t);
        @(negedge clk);
        drive(x, y, s, t, 1'b1);
        @(posedge clk);
        @(negedge clk);
        drive(~x, x, ~s, ~t, 1'b0);
        for (int k = 0; k < 3; k++) begin
            lat[k] = 0;
            dc[k]  = 0;
        end
        for (int e = 1; e <= 14; e++) begin
            @(posedge clk);
            #1;
            if (b2.done) begin
                dc[0]++;
                if (lat[0] == 0) begin lat[0] = e; r[0] = b2.out; bw[0] = b2.borrow; vf[0] = b2.overflow; end
            end
            if (b8.done) begin
                dc[1]++;
                if (lat[1] == 0) begin lat[1] = e; r[1] = b8.out; bw[1] = b8.borrow; vf[1] = b8.overflow; end
            end
            if (b1.done) begin
                dc[2]++;
                if (lat[2] == 0) begin lat[2] = e; r[2] = b1.out; bw[2] = b1.borrow; vf[2] = b1.overflow; end
            end
        end
    endtask

    task automatic test_reset();
        #1;
        vectors++;
        if ({b2.busy, b2.done, b2.out, b2.borrow, b2.overflow} !== 12'h000) begin
            miscompares++;
            $display("FAIL reset_state got busy=%b done=%b out=%h borrow=%b ovf=%b required all 0",
                     b2.busy, b2.done, b2.out, b2.borrow, b2.overflow);
        end
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
        vectors++;
        if ({b2.busy, b2.done, b2.out, b8.out, b1.out} !== 26'h0) begin
            miscompares++;
            $display("FAIL post_reset_idle got busy=%b done=%b outs=%h/%h/%h required all 0",
                     b2.busy, b2.done, b2.out, b8.out, b1.out);
        end
    endtask

    task automatic test_arith(input string name, input logic [7:0] x, input logic [7:0] y,
                              input logic s, input logic t,
                              input logic [7:0] er, input logic eb, input logic ev);
        op(x, y, s, t);
        for (int k = 0; k < 3; k++) begin
            vectors++;
            if (lat[k] !== exp_lat[k]) begin
                miscompares++;
                $display("FAIL %s latency build%0d got %0d required %0d", name, k, lat[k], exp_lat[k]);
            end
            vectors++;
            if (dc[k] !== 1) begin
                miscompares++;
                $display("FAIL %s done_pulses build%0d got %0d required 1", name, k, dc[k]);
            end
            vectors++;
            if ({r[k], bw[k], vf[k]} !== {er, eb, ev}) begin
                miscompares++;
                $display("FAIL %s result build%0d got out=%h borrow=%b ovf=%b required out=%h borrow=%b ovf=%b",
                         name, k, r[k], bw[k], vf[k], er, eb, ev);
            end
        end
        vectors++;
        if ({b2.busy, b8.busy, b1.busy} !== 3'b000) begin
            miscompares++;
            $display("FAIL %s busy_after got %b required 000", name, {b2.busy, b8.busy, b1.busy});
        end
    endtask

    task automatic test_mid_reset();
        @(negedge clk);
        drive(8'd125, 8'd100, 1'b0, 1'b0, 1'b1);
        @(posedge clk);
        @(negedge clk);
        drive(8'd125, 8'd100, 1'b0, 1'b0, 1'b0);
        @(posedge clk);
        #2;
        rst = 1'b1;
        #1;
        vectors++;
        if ({b2.busy, b2.done, b2.out, b2.borrow, b2.overflow} !== 12'h000) begin
            miscompares++;
            $display("FAIL mid_reset got busy=%b done=%b out=%h borrow=%b ovf=%b required all 0",
                     b2.busy, b2.done, b2.out, b2.borrow, b2.overflow);
        end
        @(negedge clk);
        rst = 1'b0;
        dc[0] = 0;
        for (int e = 0; e < 12; e++) begin
            @(posedge clk);
            #1;
            if (b2.done | b8.done | b1.done) dc[0]++;
        end
        vectors++;
        if (dc[0] !== 0 || b2.out !== 8'h00) begin
            miscompares++;
            $display("FAIL mid_reset_no_done got pulses=%0d out=%h required 0 and 00", dc[0], b2.out);
        end
    endtask

    task automatic test_start_ignored();
        int pulses;
        @(negedge clk);
        b2.in1 = 8'd200; b2.in2 = 8'd100; b2.mode_signed = 1'b0; b2.saturate = 1'b0; b2.start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        b2.start = 1'b0;
        @(negedge clk);
        b2.in1 = 8'd1; b2.in2 = 8'd2; b2.start = 1'b1;
        vectors++;
        if (b2.busy !== 1'b1) begin
            miscompares++;
            $display("FAIL ignored_busy got %b required 1", b2.busy);
        end
        @(negedge clk);
        b2.start = 1'b0;
        pulses = 0;
        for (int e = 0; e < 20; e++) begin
            @(posedge clk);
            #1;
            if (b2.done) pulses++;
        end
        vectors++;
        if (pulses !== 1 || b2.out !== 8'd100 || b2.borrow !== 1'b0) begin
            miscompares++;
            $display("FAIL start_ignored got pulses=%0d out=%0d borrow=%b required 1, 100, 0",
                     pulses, b2.out, b2.borrow);
        end
    endtask

    task automatic test_back_to_back();
        int e;
        @(negedge clk);
        b2.in1 = 8'd50; b2.in2 = 8'd20; b2.mode_signed = 1'b0; b2.saturate = 1'b0; b2.start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        b2.start = 1'b0;
        e = 0;
        do begin
            @(posedge clk);
            #1;
            e++;
        end while (!b2.done && e < 20);
        vectors++;
        if (b2.done !== 1'b1 || b2.out !== 8'd30) begin
            miscompares++;
            $display("FAIL b2b_first got done=%b out=%0d required 1, 30", b2.done, b2.out);
        end
        @(posedge clk);
        #1;
        vectors++;
        if (b2.busy !== 1'b0 || b2.done !== 1'b0) begin
            miscompares++;
            $display("FAIL b2b_idle got busy=%b done=%b required 0 0", b2.busy, b2.done);
        end
        @(negedge clk);
        b2.in1 = 8'd10; b2.in2 = 8'd30; b2.start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        b2.start = 1'b0;
        e = 0;
        do begin
            @(posedge clk);
            #1;
            e++;
        end while (!b2.done && e < 20);
        vectors++;
        if (e !== 5 || b2.out !== 8'd236 || b2.borrow !== 1'b1 || b2.overflow !== 1'b0) begin
            miscompares++;
            $display("FAIL b2b_second got latency=%0d out=%0d borrow=%b ovf=%b required 5, 236, 1, 0",
                     e, b2.out, b2.borrow, b2.overflow);
        end
    endtask

    initial begin
        drive(8'd0, 8'd0, 1'b0, 1'b0, 1'b0);
        test_reset();
        test_arith("basic",      8'd125, 8'd100, 1'b0, 1'b0, 8'd25,  1'b0, 1'b0);
        test_arith("uns_wrap",   8'd0,   8'd1,   1'b0, 1'b0, 8'd255, 1'b1, 1'b0);
        test_arith("uns_sat",    8'd0,   8'd1,   1'b0, 1'b1, 8'd0,   1'b1, 1'b0);
        test_arith("sgn_wrap",   8'h80,  8'h01,  1'b1, 1'b0, 8'h7F,  1'b0, 1'b1);
        test_arith("sgn_sat_lo", 8'h80,  8'h01,  1'b1, 1'b1, 8'h80,  1'b0, 1'b1);
        test_arith("sgn_sat_hi", 8'h7F,  8'hFF,  1'b1, 1'b1, 8'h7F,  1'b1, 1'b1);
        test_arith("equal",      8'd200, 8'd200, 1'b1, 1'b1, 8'd0,   1'b0, 1'b0);
        test_arith("uns_no_ovf", 8'h80,  8'h01,  1'b0, 1'b1, 8'h7F,  1'b0, 1'b0);
        test_mid_reset();
        test_arith("after_rst",  8'd125, 8'd100, 1'b0, 1'b0, 8'd25,  1'b0, 1'b0);
        test_start_ignored();
        test_back_to_back();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
